// File: rtl/top_ram_pkg.sv
// Shared definitions for the scratch RAM and its clear controller.
package top_ram_pkg;

   localparam int ADDR_W_DEF = 7;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

   typedef logic [DATA_W_DEF-1:0] word_t;
   typedef logic [ADDR_W_DEF-1:0] addr_t;

   // Clear-engine states
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } clr_state_t;

endpackage

// File: rtl/top_ram_clear_ctrl.sv
// Post-reset zero-fill sweep and the write-port mux between sweep and user.
//
// state    | meaning
// ST_CLEAR | sweeping mem[ptr] <= 0, user accesses ignored
// ST_READY | sweep done, user writes routed to the array
module top_ram_clear_ctrl
   import top_ram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              ready
);

   localparam logic [ADDR_W-1:0] PTR_LAST = '1;
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   clr_state_t        state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;

   // State and pointer registers; reset restarts the sweep from address 0
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Next state and write-port selection
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      mem_we    = 1'b0;
      mem_addr  = addr;
      mem_din   = din;
      unique case (state)
         ST_CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = ptr;
            mem_din  = '0;
            // pointer parks on the last address instead of wrapping
            if (ptr == PTR_LAST) begin
               state_nxt = ST_READY;
            end else begin
               ptr_nxt = ptr + PTR_ONE;
            end
         end
         ST_READY: begin
            mem_we = wen;
         end
         default: begin
            state_nxt = ST_CLEAR;
            ptr_nxt   = '0;
         end
      endcase
      // the array must not change on an edge where reset is sampled low
      if (!rst_n) begin
         mem_we = 1'b0;
      end
   end

   assign ready = (state == ST_READY);

endmodule

// File: rtl/top_ram.sv
// Single-port synchronous scratch RAM with post-reset zero fill,
// write-through on writes and one-cycle registered read data.
module top_ram
   import top_ram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              ready
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;

   top_ram_clear_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_clear_ctrl (
      .clk      (clk),
      .rst_n    (rst_n),
      .wen      (wen),
      .addr     (addr),
      .din      (din),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .ready    (ready)
   );

   // Storage array; written by either the clear sweep or the user port
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_din;
      end
   end

   // Output register: zero until ready, then write-through or read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (!ready) begin
         dout <= '0;
      end else if (wen) begin
         dout <= din;
      end else begin
         dout <= mem[addr];
      end
   end

endmodule

// File: tb/tb_top_ram.sv
// Directed bench for top_ram: vector table plus reset/sweep sequences.
module tb_top_ram;
   import top_ram_pkg::*;

   logic  clk;
   logic  rst_n;
   logic  wen;
   addr_t addr;
   word_t din;
   word_t dout;
   logic  ready;

   int n_cmp = 0;
   int n_bad = 0;

   top_ram dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wen   (wen),
      .addr  (addr),
      .din   (din),
      .dout  (dout),
      .ready (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic  wen;
      addr_t addr;
      word_t din;
      word_t exp_dout;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs the sweep from reset release, optionally pulsing a user write at
   // edge pulse_at; returns edges until ready and whether dout stayed 0.
   task automatic run_sweep(input int pulse_at, output int edges, output bit dout_zero);
      edges     = 0;
      dout_zero = 1'b1;
      while (!ready && edges < 300) begin
         if (edges == pulse_at) begin
            wen  = 1'b1;
            addr = 7'd5;
            din  = 8'd77;
         end else begin
            wen  = 1'b0;
            addr = '0;
            din  = '0;
         end
         tick();
         edges++;
         if (dout !== 8'h00) dout_zero = 1'b0;
      end
      wen = 1'b0;
   endtask

   initial begin
      int  edges;
      bit  dz;

      vecs[0]  = '{1'b1, 7'd12,  8'd123, 8'd123};
      vecs[1]  = '{1'b0, 7'd12,  8'd0,   8'd123};
      vecs[2]  = '{1'b0, 7'd12,  8'd0,   8'd123};
      vecs[3]  = '{1'b1, 7'd0,   8'hA5,  8'hA5};
      vecs[4]  = '{1'b1, 7'd127, 8'h5A,  8'h5A};
      vecs[5]  = '{1'b0, 7'd0,   8'h00,  8'hA5};
      vecs[6]  = '{1'b0, 7'd127, 8'h00,  8'h5A};
      vecs[7]  = '{1'b0, 7'd1,   8'h00,  8'h00};
      vecs[8]  = '{1'b0, 7'd126, 8'h00,  8'h00};
      vecs[9]  = '{1'b1, 7'd40,  8'h3C,  8'h3C};
      vecs[10] = '{1'b0, 7'd40,  8'h00,  8'h3C};
      vecs[11] = '{1'b1, 7'd40,  8'hFF,  8'hFF};
      vecs[12] = '{1'b0, 7'd40,  8'h00,  8'hFF};
      vecs[13] = '{1'b0, 7'd5,   8'h00,  8'h00};
      vecs[14] = '{1'b0, 7'd12,  8'h00,  8'd123};

      rst_n = 1'b0;
      wen   = 1'b0;
      addr  = '0;
      din   = '0;
      tick();
      tick();
      check("reset_ready", int'(ready), 0);
      check("reset_dout", int'(dout), 0);

      // release reset; user write to addr 5 attempted mid-sweep
      rst_n = 1'b1;
      run_sweep(50, edges, dz);
      check("sweep1_edges", edges, 128);
      check("sweep1_dout_zero", int'(dz), 1);
      check("sweep1_ready", int'(ready), 1);

      foreach (vecs[i]) begin
         wen  = vecs[i].wen;
         addr = vecs[i].addr;
         din  = vecs[i].din;
         tick();
         check($sformatf("vec%0d_dout", i), int'(dout), int'(vecs[i].exp_dout));
         check($sformatf("vec%0d_ready", i), int'(ready), 1);
      end

      // dout holds while the same read address is presented
      wen  = 1'b0;
      addr = 7'd127;
      tick();
      tick();
      check("hold_dout", int'(dout), 8'h5A);

      // reset in mid-operation: stored data is wiped by the new sweep
      wen  = 1'b1;
      addr = 7'd20;
      din  = 8'd99;
      tick();
      wen  = 1'b0;
      tick();
      check("pre_reset_read20", int'(dout), 99);
      rst_n = 1'b0;
      tick();
      check("midreset_ready", int'(ready), 0);
      check("midreset_dout", int'(dout), 0);
      rst_n = 1'b1;
      run_sweep(-1, edges, dz);
      check("sweep2_edges", edges, 128);
      check("sweep2_dout_zero", int'(dz), 1);

      wen  = 1'b0;
      addr = 7'd20;
      tick();
      check("post_reset_read20", int'(dout), 0);
      addr = 7'd40;
      tick();
      check("post_reset_read40", int'(dout), 0);
      addr = 7'd127;
      tick();
      check("post_reset_read127", int'(dout), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/top_ram.md
Name: top_ram

Overview:
- Single-port synchronous RAM, 128 x 8 by default, with one write-enable and a shared address bus.
- After reset, an internal clear engine zero-fills the whole array; `ready` signals when it is done.
- Used as a small scratch/lookup memory inside the top-level datapath.
- Read data is registered, with one-cycle latency.

Parameters:
- ADDR_W, 7, address width in bits.
- DATA_W, 8, data word width in bits.
- DEPTH, 2**ADDR_W (128), number of words; always the full address space.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- wen  input  1  write enable; 1 = write din to addr, 0 = read addr.
- addr  input  ADDR_W  word address for the read or write.
- din  input  DATA_W  write data.
- dout  output  DATA_W  registered read data.
- ready  output  1  high when the clear sweep is complete and accesses are accepted.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, port rst_n, sampled only on the rising edge of clk.
- While rst_n = 0 at a clock edge:
  - dout <= 0, ready <= 0, clear pointer <= 0.
  - The memory array is not modified on that edge.
- Clear sweep, starting on the first edge with rst_n = 1:
  - Each edge writes 0 to mem[clr_ptr], then increments clr_ptr.
  - After the write to address DEPTH-1, ready <= 1 on that same edge. The sweep therefore takes DEPTH cycles, and ready is first seen high DEPTH edges after reset release.
  - The pointer does not wrap; it stops once ready = 1.
- While ready = 0:
  - wen, addr and din are ignored.
  - dout is held at 0.
  - No user write reaches the array.
- Reset asserted mid-sweep or mid-operation: the sweep restarts from address 0 and ready drops to 0 on that edge. Contents already written are not guaranteed; all are zeroed again by the new sweep.
- Normal operation (ready = 1), each rising edge:
  - wen = 1: mem[addr] <= din, and dout <= din (write-through; new data visible on dout after the same edge).
  - wen = 0: dout <= mem[addr] (one-cycle read latency); the array is unchanged.
- Data persists until overwritten or reset; there is no power-on initial content other than the clear sweep.
- Address bounds: all 2**ADDR_W addresses are valid. No out-of-range case exists and there is no wrap logic.
- Back-to-back accesses: a write at cycle N followed by a read of the same address at cycle N+1 returns the new data at N+1.
- Outputs hold their values between accesses; dout is never X once the first reset has been applied.

Decomposition:
- Shared package top_ram_pkg holds:
  - default ADDR_W/DATA_W constants;
  - a data word typedef;
  - an address typedef.
- One natural sub-module: top_ram_clear_ctrl (clear pointer, ready flag, and the mux selecting the clear write vs the user write).
- The storage array and output register stay in top_ram.

Test Plan:
- Reset release: rst_n low 2 cycles, then high -> ready = 0 for exactly 128 edges, then 1; dout = 0 throughout.
- Basic write/read: after ready, wen=1 addr=12 din=123 for one edge, then wen=0 addr=12 -> dout = 123 one edge later, and stays 123 while addr = 12.
- Boundaries: write 0xA5 at addr 0 and 0x5A at addr 127, then read both -> 0xA5 and 0x5A; addr 1 and addr 126 read 0x00.
- Write-through and back-to-back: wen=1 addr=40 din=0x3C -> dout = 0x3C on the same edge; next cycle read addr 40 -> 0x3C; overwrite with 0xFF and read -> 0xFF.
- Access during clear: pulse wen=1 addr=5 din=77 while ready=0 -> dout stays 0; after ready, read addr 5 -> 0.
- Reset mid-operation: write 99 to addr 20, assert rst_n low one cycle -> ready drops, 128-cycle sweep repeats; read addr 20 afterwards -> 0.
